multi_pixel_tdc_checker: RTL and testbench

- Parametrised next-generation checker for ETROC2 readout test benches and on-chip/FPGA self-test.
- Consumes pixel TDC test-pattern words (pixel ID, BCID, per-pixel incrementing counter) from the readout path.
- Tracks per-pixel counter continuity, BCID consistency within back-to-back hit bursts, and first-error capture.
- Generalises pixel count and field widths, adds a 2-stage pipeline with same-pixel forwarding, saturating statistics, freeze/clear controls, and a first-error capture register.

---
 rtl/etroc2_chk_pkg.sv | 25 ++
 rtl/sat_accum.sv | 34 +++
 rtl/multi_pixel_tdc_checker.sv | 126 ++++++++++++
 tb/tb_multi_pixel_tdc_checker.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/etroc2_chk_pkg.sv
// etroc2_chk_pkg: field offsets of the TDC test-pattern word and modular count distance
package etroc2_chk_pkg;

   localparam int DEF_PIX_ID_W = 8;
   localparam int DEF_BCID_W   = 12;
   localparam int DEF_CNT_W    = 9;
   localparam int DEF_STAT_W   = 20;

   function automatic int cnt_lsb();
      return 0;
   endfunction

   function automatic int bcid_lsb(input int cnt_w);
      return cnt_w;
   endfunction

   function automatic int pix_lsb(input int bcid_w, input int cnt_w);
      return bcid_w + cnt_w;
   endfunction

   function automatic logic [31:0] mod_dist(input logic [31:0] got, input logic [31:0] expd, input int w);
      return (got - expd) & ((32'd1 << w) - 32'd1);
   endfunction

endpackage

// File: rtl/sat_accum.sv
// sat_accum: accumulator that clamps at all-ones and flags when its next value is all-ones
module sat_accum #(
   parameter int W  = 20,
   parameter int AW = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          en,
   input  logic [AW-1:0] add,
   output logic [W-1:0]  q,
   output logic          sat
);

   localparam int SW = (W > AW ? W : AW) + 1;

   logic [SW-1:0] sum;
   logic [W-1:0]  nxt;

   // widened sum so overflow past W bits clamps to all-ones
   always_comb begin
      sum = SW'(q) + SW'(add);
      nxt = !en ? q : (|sum[SW-1:W]) ? '1 : sum[W-1:0];
   end

   assign sat = &nxt;

   // register the clamped value
   always_ff @(posedge clk) begin
      if (reset || clear) q <= '0;
      else                q <= nxt;
   end

endmodule

// File: rtl/multi_pixel_tdc_checker.sv
// multi_pixel_tdc_checker: per-pixel counter continuity and in-burst BCID checker
module multi_pixel_tdc_checker
   import etroc2_chk_pkg::*;
#(
   parameter int PIX_ID_W = DEF_PIX_ID_W,
   parameter int BCID_W   = DEF_BCID_W,
   parameter int CNT_W    = DEF_CNT_W,
   parameter int STAT_W   = DEF_STAT_W
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clear,
   input  logic                         freeze,
   input  logic                         hit_valid,
   input  logic [PIX_ID_W+BCID_W+CNT_W-1:0] tdc_data,
   output logic [STAT_W-1:0]            total_hit,
   output logic [STAT_W-1:0]            error_count,
   output logic [STAT_W-1:0]            missed_count,
   output logic [STAT_W-1:0]            bcid_mismatch_count,
   output logic [PIX_ID_W:0]            hitted_pixel_count,
   output logic                         stat_saturated,
   output logic                         first_err_valid,
   output logic [PIX_ID_W-1:0]          first_err_pixel,
   output logic [CNT_W-1:0]             first_err_expected,
   output logic [CNT_W-1:0]             first_err_got
);

   localparam int NUM_PIX = 2**PIX_ID_W;
   localparam int CL      = cnt_lsb();
   localparam int BL      = bcid_lsb(CNT_W);
   localparam int PL      = pix_lsb(BCID_W, CNT_W);

   logic [CNT_W-1:0]    cnt_table [NUM_PIX];
   logic [NUM_PIX-1:0]  hitted;
   logic                flush, accept;
   logic [PIX_ID_W-1:0] in_pix, s1_pix, s2_pix;
   logic [BCID_W-1:0]   in_bcid, s1_bcid;
   logic [CNT_W-1:0]    in_cnt, s1_cnt, s2_cnt, s2_prev, rd_prev, exp_cnt, miss;
   logic                s1_v, s1_mm, s2_v, s2_mm, s2_hit, rd_hit, fwd, err;
   logic [3:0]          sat;

   assign flush   = reset | clear;
   assign accept  = hit_valid & ~freeze & ~flush;
   assign in_pix  = tdc_data[PL +: PIX_ID_W];
   assign in_bcid = tdc_data[BL +: BCID_W];
   assign in_cnt  = tdc_data[CL +: CNT_W];

   // S1 table read, forwarding the S2 count when both stages hold the same pixel
   always_comb begin
      fwd     = s2_v && (s2_pix == s1_pix);
      rd_prev = fwd ? s2_cnt : cnt_table[s1_pix];
      rd_hit  = fwd | hitted[s1_pix];
      exp_cnt = s2_prev + CNT_W'(1);
      err     = s2_v & s2_hit & (s2_cnt != exp_cnt);
      miss    = err ? CNT_W'(mod_dist(32'(s2_cnt), 32'(exp_cnt), CNT_W)) : '0;
   end

   // pipeline valids; S1 valid doubles as the burst flag for the next accepted hit
   always_ff @(posedge clk) begin
      if (flush) begin
         s1_v <= 1'b0;
         s2_v <= 1'b0;
      end else begin
         s1_v <= accept;
         s2_v <= s1_v;
      end
   end

   // pipeline payload; mismatch is judged against the hit accepted one cycle earlier
   always_ff @(posedge clk) begin
      s1_mm   <= accept & s1_v & (in_bcid != s1_bcid);
      s1_pix  <= in_pix;
      s1_bcid <= in_bcid;
      s1_cnt  <= in_cnt;
      s2_mm   <= s1_mm;
      s2_pix  <= s1_pix;
      s2_cnt  <= s1_cnt;
      s2_prev <= rd_prev;
      s2_hit  <= rd_hit;
   end

   // count table is never reset; the hitted bitmap masks stale entries
   always_ff @(posedge clk) begin
      if (s2_v && !flush) cnt_table[s2_pix] <= s2_cnt;
   end

   // pixel bitmap, distinct-pixel count, first-error capture and sticky saturation
   always_ff @(posedge clk) begin
      if (flush) begin
         hitted             <= '0;
         hitted_pixel_count <= '0;
         first_err_valid    <= 1'b0;
         first_err_pixel    <= '0;
         first_err_expected <= '0;
         first_err_got      <= '0;
         stat_saturated     <= 1'b0;
      end else begin
         if (s2_v) hitted[s2_pix] <= 1'b1;
         if (s2_v && !s2_hit) hitted_pixel_count <= hitted_pixel_count + (PIX_ID_W+1)'(1);
         if (err && !first_err_valid) begin
            first_err_valid    <= 1'b1;
            first_err_pixel    <= s2_pix;
            first_err_expected <= exp_cnt;
            first_err_got      <= s2_cnt;
         end
         stat_saturated <= stat_saturated | (|sat);
      end
   end

   sat_accum #(.W(STAT_W), .AW(1)) u_total (
      .clk(clk), .reset(reset), .clear(clear), .en(s2_v), .add(1'b1), .q(total_hit), .sat(sat[0])
   );

   sat_accum #(.W(STAT_W), .AW(1)) u_error (
      .clk(clk), .reset(reset), .clear(clear), .en(err), .add(1'b1), .q(error_count), .sat(sat[1])
   );

   sat_accum #(.W(STAT_W), .AW(CNT_W)) u_missed (
      .clk(clk), .reset(reset), .clear(clear), .en(err), .add(miss), .q(missed_count), .sat(sat[2])
   );

   sat_accum #(.W(STAT_W), .AW(1)) u_mismatch (
      .clk(clk), .reset(reset), .clear(clear), .en(s2_v & s2_mm), .add(1'b1), .q(bcid_mismatch_count), .sat(sat[3])
   );

endmodule

// File: tb/tb_multi_pixel_tdc_checker.sv
// tb_multi_pixel_tdc_checker: directed vectors against hand-computed statistics
module tb_multi_pixel_tdc_checker;

   logic        clk = 1'b0;
   logic        reset, clear, freeze, hit_valid;
   logic [28:0] tdc_data;

   logic [19:0] total_hit, error_count, missed_count, bcid_mismatch_count;
   logic [8:0]  hitted_pixel_count;
   logic        stat_saturated, first_err_valid;
   logic [7:0]  first_err_pixel;
   logic [8:0]  first_err_expected, first_err_got;

   logic [3:0]  t4_total, t4_error, t4_missed, t4_mm;
   logic [8:0]  t4_hitted;
   logic        t4_sat, t4_fev;
   logic [7:0]  t4_fep;
   logic [8:0]  t4_fee, t4_feg;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   multi_pixel_tdc_checker dut (
      .clk(clk), .reset(reset), .clear(clear), .freeze(freeze), .hit_valid(hit_valid), .tdc_data(tdc_data),
      .total_hit(total_hit), .error_count(error_count), .missed_count(missed_count),
      .bcid_mismatch_count(bcid_mismatch_count), .hitted_pixel_count(hitted_pixel_count),
      .stat_saturated(stat_saturated), .first_err_valid(first_err_valid), .first_err_pixel(first_err_pixel),
      .first_err_expected(first_err_expected), .first_err_got(first_err_got)
   );

   multi_pixel_tdc_checker #(.STAT_W(4)) dut4 (
      .clk(clk), .reset(reset), .clear(clear), .freeze(freeze), .hit_valid(hit_valid), .tdc_data(tdc_data),
      .total_hit(t4_total), .error_count(t4_error), .missed_count(t4_missed),
      .bcid_mismatch_count(t4_mm), .hitted_pixel_count(t4_hitted),
      .stat_saturated(t4_sat), .first_err_valid(t4_fev), .first_err_pixel(t4_fep),
      .first_err_expected(t4_fee), .first_err_got(t4_feg)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expd);
      checks++;
      if (got !== expd) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, expd);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic hit(input int p, input int b, input int c);
      hit_valid = 1'b1;
      tdc_data  = {8'(p), 12'(b), 9'(c)};
      tick();
      hit_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b0; clear = 1'b0; freeze = 1'b0; hit_valid = 1'b0; tdc_data = '0;
      do_reset();
      chk("rst_total", 32'(total_hit), 0);
      chk("rst_hitted", 32'(hitted_pixel_count), 0);
      chk("rst_error", 32'(error_count), 0);
      chk("rst_missed", 32'(missed_count), 0);
      chk("rst_mm", 32'(bcid_mismatch_count), 0);
      chk("rst_sat", 32'(stat_saturated), 0);
      chk("rst_fev", 32'(first_err_valid), 0);

      hit(5, 10, 0);
      hit(5, 10, 1);
      chk("lat_1", 32'(total_hit), 0);
      hit(5, 10, 2);
      chk("lat_2", 32'(total_hit), 1);
      hit(5, 10, 3);
      idle(2);
      chk("p5_total", 32'(total_hit), 4);
      chk("p5_hitted", 32'(hitted_pixel_count), 1);
      chk("p5_error", 32'(error_count), 0);
      chk("p5_mm", 32'(bcid_mismatch_count), 0);

      hit(7, 10, 510);
      hit(7, 10, 3);
      idle(2);
      chk("p7_error", 32'(error_count), 1);
      chk("p7_missed", 32'(missed_count), 4);
      chk("p7_fev", 32'(first_err_valid), 1);
      chk("p7_fep", 32'(first_err_pixel), 7);
      chk("p7_fee", 32'(first_err_expected), 511);
      chk("p7_feg", 32'(first_err_got), 3);

      hit(9, 10, 0);
      hit(9, 10, 5);
      idle(2);
      chk("p9_error", 32'(error_count), 2);
      chk("p9_missed", 32'(missed_count), 8);
      chk("p9_fep", 32'(first_err_pixel), 7);
      chk("p9_fee", 32'(first_err_expected), 511);
      chk("p9_feg", 32'(first_err_got), 3);
      chk("p9_total", 32'(total_hit), 8);

      hit(20, 100, 0);
      hit(21, 100, 0);
      hit(22, 101, 0);
      idle(1);
      hit(23, 200, 0);
      idle(2);
      chk("bc_mm", 32'(bcid_mismatch_count), 1);
      chk("bc_total", 32'(total_hit), 12);
      chk("bc_hitted", 32'(hitted_pixel_count), 7);

      do_reset();
      for (int p = 0; p < 256; p++) hit(p, 0, p);
      hit(0, 0, 1);
      idle(2);
      chk("all_hitted", 32'(hitted_pixel_count), 256);
      chk("all_total", 32'(total_hit), 257);
      chk("all_error", 32'(error_count), 0);
      chk("all_mm", 32'(bcid_mismatch_count), 0);

      freeze = 1'b1;
      hit(0, 0, 50);
      hit(0, 0, 50);
      hit(0, 0, 50);
      freeze = 1'b0;
      idle(3);
      chk("frz_total", 32'(total_hit), 257);
      chk("frz_error", 32'(error_count), 0);
      clear = 1'b1;
      hit(0, 0, 77);
      clear = 1'b0;
      chk("clr_total", 32'(total_hit), 0);
      chk("clr_hitted", 32'(hitted_pixel_count), 0);
      idle(2);
      chk("clr_drop", 32'(total_hit), 0);
      hit(0, 0, 100);
      idle(2);
      chk("clr_first_total", 32'(total_hit), 1);
      chk("clr_first_hitted", 32'(hitted_pixel_count), 1);
      chk("clr_first_error", 32'(error_count), 0);

      do_reset();
      for (int i = 0; i < 14; i++) hit(1, 5, i);
      idle(2);
      chk("s4_total14", 32'(t4_total), 14);
      chk("s4_sat14", 32'(t4_sat), 0);
      for (int i = 14; i < 20; i++) hit(1, 5, i);
      idle(2);
      chk("s4_total20", 32'(t4_total), 15);
      chk("s4_sat20", 32'(t4_sat), 1);
      chk("s20_total", 32'(total_hit), 20);
      chk("s20_error", 32'(error_count), 0);

      hit(2, 5, 0);
      hit(2, 5, 1);
      reset = 1'b1;
      hit_valid = 1'b1;
      tick();
      reset = 1'b0;
      hit_valid = 1'b0;
      chk("mid_t4_total", 32'(t4_total), 0);
      chk("mid_t4_sat", 32'(t4_sat), 0);
      chk("mid_total", 32'(total_hit), 0);
      chk("mid_hitted", 32'(hitted_pixel_count), 0);
      idle(3);
      chk("mid_drop", 32'(total_hit), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
